// File: rtl/shtlb_miss_arbiter_if.sv
// Request/response and shared-TLB/PTW bundle for the shared-TLB miss arbiter.
// slave is the arbiter's view; master is the surrounding MMU (first-level TLBs, shared TLB, PTW).
interface shtlb_miss_arbiter_if #(
   parameter int VPN_WIDTH  = 20,
   parameter int ASID_WIDTH = 9,
   parameter int PPN_WIDTH  = 22
);
   logic                  flush_i;

   logic                  itlb_req_i;
   logic [VPN_WIDTH-1:0]  itlb_vpn_i;
   logic [ASID_WIDTH-1:0] itlb_asid_i;
   logic                  itlb_ack_o;
   logic                  itlb_valid_o;

   logic                  dtlb_req_i;
   logic [VPN_WIDTH-1:0]  dtlb_vpn_i;
   logic [ASID_WIDTH-1:0] dtlb_asid_i;
   logic                  dtlb_ack_o;
   logic                  dtlb_valid_o;

   logic [PPN_WIDTH-1:0]  resp_ppn_o;
   logic                  resp_fault_o;

   logic                  shtlb_lookup_o;
   logic [VPN_WIDTH-1:0]  shtlb_vpn_o;
   logic [ASID_WIDTH-1:0] shtlb_asid_o;
   logic                  shtlb_hit_i;
   logic [PPN_WIDTH-1:0]  shtlb_ppn_i;

   logic                  ptw_req_o;
   logic [VPN_WIDTH-1:0]  ptw_vpn_o;
   logic [ASID_WIDTH-1:0] ptw_asid_o;
   logic                  ptw_ready_i;
   logic                  ptw_done_i;
   logic [PPN_WIDTH-1:0]  ptw_ppn_i;
   logic                  ptw_fault_i;

   modport slave (
      input  flush_i,
      input  itlb_req_i, itlb_vpn_i, itlb_asid_i,
      output itlb_ack_o, itlb_valid_o,
      input  dtlb_req_i, dtlb_vpn_i, dtlb_asid_i,
      output dtlb_ack_o, dtlb_valid_o,
      output resp_ppn_o, resp_fault_o,
      output shtlb_lookup_o, shtlb_vpn_o, shtlb_asid_o,
      input  shtlb_hit_i, shtlb_ppn_i,
      output ptw_req_o, ptw_vpn_o, ptw_asid_o,
      input  ptw_ready_i, ptw_done_i, ptw_ppn_i, ptw_fault_i
   );

   modport master (
      output flush_i,
      output itlb_req_i, itlb_vpn_i, itlb_asid_i,
      input  itlb_ack_o, itlb_valid_o,
      output dtlb_req_i, dtlb_vpn_i, dtlb_asid_i,
      input  dtlb_ack_o, dtlb_valid_o,
      input  resp_ppn_o, resp_fault_o,
      input  shtlb_lookup_o, shtlb_vpn_o, shtlb_asid_o,
      output shtlb_hit_i, shtlb_ppn_i,
      input  ptw_req_o, ptw_vpn_o, ptw_asid_o,
      output ptw_ready_i, ptw_done_i, ptw_ppn_i, ptw_fault_i
   );
endinterface

// File: rtl/shtlb_miss_arbiter.sv
// Arbitrates ITLB/DTLB misses onto the shared TLB and page-table walker, one at a time.
// Define SHTLB_ARB_PERF_EN to add the hit/miss performance counters.
module shtlb_miss_arbiter #(
   parameter int VPN_WIDTH    = 20,
   parameter int ASID_WIDTH   = 9,
   parameter int PPN_WIDTH    = 22,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   shtlb_miss_arbiter_if.slave  bus
`ifdef SHTLB_ARB_PERF_EN
   ,
   output logic [15:0]          hit_cnt_o,
   output logic [15:0]          miss_cnt_o
`endif
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOOKUP, S_CHECK, S_PTW_REQ, S_PTW_WAIT, S_RESP, S_DRAIN
   } state_e;

   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   state_e                state_q, state_d;
   logic                  owner_q, owner_d;   // 1: DTLB owns the transaction
   logic [VPN_WIDTH-1:0]  vpn_q, vpn_d;
   logic [ASID_WIDTH-1:0] asid_q, asid_d;
   logic [PPN_WIDTH-1:0]  ppn_q, ppn_d;
   logic                  fault_q, fault_d;
   logic [3:0]            starve_q, starve_d;

   logic grant, pick_d, pick_i;

   // DTLB wins unless an ITLB request has already waited out STARVE_LIMIT data grants.
   assign pick_d = bus.dtlb_req_i && !(bus.itlb_req_i && starve_q == STARVE_MAX);
   assign pick_i = bus.itlb_req_i && !pick_d;
   assign grant  = (state_q == S_IDLE) && !bus.flush_i && (bus.itlb_req_i || bus.dtlb_req_i);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         owner_q  <= 1'b0;
         vpn_q    <= '0;
         asid_q   <= '0;
         ppn_q    <= '0;
         fault_q  <= 1'b0;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         vpn_q    <= vpn_d;
         asid_q   <= asid_d;
         ppn_q    <= ppn_d;
         fault_q  <= fault_d;
         starve_q <= starve_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     if (grant) state_d = S_LOOKUP;
         S_LOOKUP:   state_d = bus.flush_i ? S_IDLE : S_CHECK;
         S_CHECK: begin
            if (bus.flush_i)          state_d = S_IDLE;
            else if (bus.shtlb_hit_i) state_d = S_RESP;
            else                      state_d = S_PTW_REQ;
         end
         S_PTW_REQ: begin
            if (bus.flush_i)          state_d = S_IDLE;
            else if (bus.ptw_ready_i) state_d = S_PTW_WAIT;
         end
         // A flush coinciding with done has nothing left to drain.
         S_PTW_WAIT: begin
            if (bus.flush_i)         state_d = bus.ptw_done_i ? S_IDLE : S_DRAIN;
            else if (bus.ptw_done_i) state_d = S_RESP;
         end
         S_RESP:     state_d = S_IDLE;
         S_DRAIN:    if (bus.ptw_done_i) state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   always_comb begin
      owner_d  = owner_q;
      vpn_d    = vpn_q;
      asid_d   = asid_q;
      ppn_d    = ppn_q;
      fault_d  = fault_q;
      starve_d = starve_q;

      if (grant) begin
         owner_d = pick_d;
         vpn_d   = pick_d ? bus.dtlb_vpn_i  : bus.itlb_vpn_i;
         asid_d  = pick_d ? bus.dtlb_asid_i : bus.itlb_asid_i;
      end

      if (!bus.itlb_req_i || (grant && pick_i))
         starve_d = '0;
      else if (grant && pick_d && starve_q != 4'hF)
         starve_d = starve_q + 4'd1;

      if (state_q == S_CHECK && !bus.flush_i && bus.shtlb_hit_i) begin
         ppn_d   = bus.shtlb_ppn_i;
         fault_d = 1'b0;
      end else if (state_q == S_PTW_WAIT && !bus.flush_i && bus.ptw_done_i) begin
         ppn_d   = bus.ptw_ppn_i;
         fault_d = bus.ptw_fault_i;
      end
   end

   always_comb begin
      bus.itlb_ack_o     = grant && pick_i;
      bus.dtlb_ack_o     = grant && pick_d;
      bus.shtlb_lookup_o = (state_q == S_LOOKUP) && !bus.flush_i;
      bus.ptw_req_o      = (state_q == S_PTW_REQ) && !bus.flush_i;
      bus.itlb_valid_o   = (state_q == S_RESP) && !bus.flush_i && !owner_q;
      bus.dtlb_valid_o   = (state_q == S_RESP) && !bus.flush_i && owner_q;
      bus.shtlb_vpn_o    = vpn_q;
      bus.shtlb_asid_o   = asid_q;
      bus.ptw_vpn_o      = vpn_q;
      bus.ptw_asid_o     = asid_q;
      bus.resp_ppn_o     = ppn_q;
      bus.resp_fault_o   = fault_q;
   end

`ifdef SHTLB_ARB_PERF_EN
   logic [15:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (bus.flush_i) begin
         hit_cnt_d  = '0;
         miss_cnt_d = '0;
      end else if (state_q == S_CHECK) begin
         if (bus.shtlb_hit_i && hit_cnt_q != 16'hFFFF)   hit_cnt_d  = hit_cnt_q + 16'd1;
         if (!bus.shtlb_hit_i && miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_cnt_o  = hit_cnt_q;
   assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
